// File: rtl/dsp48a1_pkg.sv
// rtl/dsp48a1_pkg.sv - OPMODE field positions and X/Z mux select encodings for dsp48_a1
package dsp48a1_pkg;

    localparam int OP_X_LSB       = 0;
    localparam int OP_Z_LSB       = 2;
    localparam int OP_B1_PREADD   = 4;
    localparam int OP_CARRY       = 5;
    localparam int OP_PREADD_SUB  = 6;
    localparam int OP_POSTADD_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO   = 2'd0,
        X_M      = 2'd1,
        X_P      = 2'd2,
        X_CONCAT = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/dsp_reg_mux.sv
// rtl/dsp_reg_mux.sv - one pipeline stage: optional register with CE and async active-low reset
module dsp_reg_mux #(
    parameter int WIDTH = 18,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (ce) begin
            q_r <= d;
        end
    end

    // REG = 0 leaves the register dangling so synthesis prunes it
    assign q = (REG != 0) ? q_r : d;

endmodule

// File: rtl/dsp48_a1.sv
// rtl/dsp48_a1.sv - DSP48A1-style pre-add/multiply/post-add slice; DSP48A1_CASCADE_EN enables BCIN as B source
module dsp48_a1
    import dsp48a1_pkg::*;
#(
    parameter int A0REG       = 0,
    parameter int A1REG       = 1,
    parameter int B0REG       = 0,
    parameter int B1REG       = 1,
    parameter int CREG        = 1,
    parameter int DREG        = 1,
    parameter int MREG        = 1,
    parameter int PREG        = 1,
    parameter int CARRYINREG  = 1,
    parameter int CARRYOUTREG = 1,
    parameter int OPMODEREG   = 1,
    parameter     CARRYINSEL  = "OPMODE5",
    parameter     B_INPUT     = "DIRECT"
) (
    input  logic        clk,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [17:0] BCIN,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    output logic [47:0] P,
    output logic [35:0] M,
    output logic [17:0] BCOUT,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    logic [7:0]  op_r;
    logic [17:0] a0_r, a1_r, b_src, b0_r, b1_in, b1_r, d_r, preadd;
    logic [47:0] c_r, p_r, x_mux, z_mux;
    logic [35:0] mult, m_r;
    logic        cin_src, cin_r, cout_r;
    logic [48:0] postadd;

    dsp_reg_mux #(.WIDTH(8), .REG(OPMODEREG)) u_opmode (
        .clk(clk), .rst_n(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op_r));

    dsp_reg_mux #(.WIDTH(18), .REG(A0REG)) u_a0 (
        .clk(clk), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0_r));
    dsp_reg_mux #(.WIDTH(18), .REG(A1REG)) u_a1 (
        .clk(clk), .rst_n(RSTA), .ce(CEA), .d(a0_r), .q(a1_r));

`ifdef DSP48A1_CASCADE_EN
    assign b_src = (B_INPUT == "CASCADE") ? BCIN : B;
`else
    // BCIN stays on the port list for drop-in compatibility but is not used
    logic unused_bcin;
    assign unused_bcin = ^BCIN ^ (B_INPUT == "CASCADE");
    assign b_src = B;
`endif

    dsp_reg_mux #(.WIDTH(18), .REG(B0REG)) u_b0 (
        .clk(clk), .rst_n(RSTB), .ce(CEB), .d(b_src), .q(b0_r));
    dsp_reg_mux #(.WIDTH(18), .REG(DREG)) u_d (
        .clk(clk), .rst_n(RSTD), .ce(CED), .d(D), .q(d_r));

    assign preadd = op_r[OP_PREADD_SUB] ? (d_r - b0_r) : (d_r + b0_r);
    assign b1_in  = op_r[OP_B1_PREADD] ? preadd : b0_r;

    dsp_reg_mux #(.WIDTH(18), .REG(B1REG)) u_b1 (
        .clk(clk), .rst_n(RSTB), .ce(CEB), .d(b1_in), .q(b1_r));

    assign mult = {18'd0, a1_r} * {18'd0, b1_r};

    dsp_reg_mux #(.WIDTH(36), .REG(MREG)) u_m (
        .clk(clk), .rst_n(RSTM), .ce(CEM), .d(mult), .q(m_r));
    dsp_reg_mux #(.WIDTH(48), .REG(CREG)) u_c (
        .clk(clk), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_r));

    always_comb begin
        x_mux = '0;
        case (x_sel_e'(op_r[OP_X_LSB +: 2]))
            X_ZERO:   x_mux = '0;
            X_M:      x_mux = {12'd0, m_r};
            X_P:      x_mux = p_r;
            X_CONCAT: x_mux = {d_r[11:0], a1_r, b1_r};
            default:  x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (z_sel_e'(op_r[OP_Z_LSB +: 2]))
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = PCIN;
            Z_P:     z_mux = p_r;
            Z_C:     z_mux = c_r;
            default: z_mux = '0;
        endcase
    end

    assign cin_src = (CARRYINSEL == "CARRYIN") ? CARRYIN : op_r[OP_CARRY];

    dsp_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
        .clk(clk), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(cin_src), .q(cin_r));

    // Subtract mode: the 49th bit of Z - (X + CIN) is the borrow
    assign postadd = op_r[OP_POSTADD_SUB]
                   ? ({1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin_r}))
                   : ({1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin_r});

    dsp_reg_mux #(.WIDTH(48), .REG(PREG)) u_p (
        .clk(clk), .rst_n(RSTP), .ce(CEP), .d(postadd[47:0]), .q(p_r));
    dsp_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_cout (
        .clk(clk), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(postadd[48]), .q(cout_r));

    assign P         = p_r;
    assign PCOUT     = p_r;
    assign M         = m_r;
    assign BCOUT     = b1_r;
    assign CARRYOUT  = cout_r;
    assign CARRYOUTF = cout_r;

endmodule

// File: tb/tb_dsp48_a1.sv
// tb/tb_dsp48_a1.sv - directed self-checking bench for dsp48_a1 with default parameters
module tb_dsp48_a1;

    logic        clk;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [47:0] P, PCOUT;
    logic [35:0] M;
    logic [17:0] BCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int passed = 0;
    int total  = 0;

    dsp48_a1 dut (
        .clk(clk),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
        .RSTM(RSTM), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
        .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .C(C), .BCIN(BCIN), .PCIN(PCIN),
        .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .P(P), .M(M), .BCOUT(BCOUT), .PCOUT(PCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_resets(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v;
        RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_resets(1'b0);
        CEA = 1; CEB = 1; CEC = 1; CED = 1; CEM = 1; CEP = 1; CECARRYIN = 1; CEOPMODE = 1;
        A = '0; B = '0; D = '0; C = '0; BCIN = 18'h3FFFF; PCIN = '0;
        CARRYIN = 1'b0; OPMODE = 8'h00;
        #2;
        check("rst_p", {16'd0, P}, 64'd0);
        check("rst_m", {28'd0, M}, 64'd0);
        check("rst_bcout", {46'd0, BCOUT}, 64'd0);
        check("rst_carryout", {63'd0, CARRYOUT}, 64'd0);

        @(negedge clk);
        set_resets(1'b1);

        OPMODE = 8'h20;
        edges(4);
        check("op20_p", {16'd0, P}, 64'd1);
        check("op20_carryout", {63'd0, CARRYOUT}, 64'd0);

        OPMODE = 8'hA0;
        edges(4);
        check("opA0_p", {16'd0, P}, 64'h0000_FFFF_FFFF_FFFF);
        check("opA0_carryout", {63'd0, CARRYOUT}, 64'd1);
        check("opA0_carryoutf", {63'd0, CARRYOUTF}, 64'd1);
        check("opA0_pcout", {16'd0, PCOUT}, 64'h0000_FFFF_FFFF_FFFF);

        OPMODE = 8'h01; A = 18'd3; B = 18'd5;
        edges(4);
        check("op01_p", {16'd0, P}, 64'd15);
        check("op01_m", {28'd0, M}, 64'd15);
        check("op01_bcout", {46'd0, BCOUT}, 64'd5);

        OPMODE = 8'h51; A = 18'd2; D = 18'd10; B = 18'd3;
        edges(4);
        check("op51_p", {16'd0, P}, 64'd14);
        check("op51_bcout", {46'd0, BCOUT}, 64'd7);

        OPMODE = 8'h33; A = 18'd1; B = 18'd2; D = 18'd3;
        edges(4);
        check("op33_p", {16'd0, P}, 64'h0000_0030_0004_0006);

        OPMODE = 8'h05; PCIN = 48'd100; A = 18'd4; B = 18'd5; D = 18'd0;
        edges(4);
        check("op05_p", {16'd0, P}, 64'd120);

        CEP = 1'b0; A = 18'd7;
        edges(4);
        check("cep0_hold_p", {16'd0, P}, 64'd120);
        check("cep0_m_moves", {28'd0, M}, 64'd35);

        CEP = 1'b1;
        edges(4);
        check("cep1_p", {16'd0, P}, 64'd135);

        // Mid-operation async reset, sampled well away from any edge
        #2;
        set_resets(1'b0);
        #1;
        check("async_rst_p", {16'd0, P}, 64'd0);
        check("async_rst_m", {28'd0, M}, 64'd0);
        check("async_rst_bcout", {46'd0, BCOUT}, 64'd0);
        check("async_rst_carryout", {63'd0, CARRYOUT}, 64'd0);

        edges(1);
        check("rst_hold_p", {16'd0, P}, 64'd0);

        set_resets(1'b1);
        edges(4);
        check("release_p", {16'd0, P}, 64'd135);
        check("release_bcout", {46'd0, BCOUT}, 64'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
